// File: rtl/bbus_pipe.sv
// Registered B-bus source multiplexer with stall hold, out-of-range select flagging
// and an optional debug scan sequencer (compiled in when BBUS_PIPE_SCAN_EN is defined).
module bbus_pipe #(
  parameter int unsigned DATA_W  = 19,
  parameter int unsigned NUM_SRC = 15,
  parameter int unsigned SEL_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_bus,
  input  logic [SEL_W-1:0]          i_b_sel,
  input  logic                      i_sel_valid,
  input  logic                      i_stall,
  input  logic                      i_scan_start,
  output logic [DATA_W-1:0]         o_b_out,
  output logic                      o_b_valid,
  output logic [SEL_W-1:0]          o_b_idx,
  output logic                      o_sel_err,
  output logic                      o_scan_busy,
  output logic                      o_scan_done
);

  localparam int unsigned        CMP_W     = SEL_W + 1;
  localparam logic [CMP_W-1:0]   NUM_SRC_C = CMP_W'(NUM_SRC);

  logic [DATA_W-1:0] r_b_out;
  logic              r_b_valid;
  logic [SEL_W-1:0]  r_b_idx;
  logic              r_sel_err;

  logic [SEL_W-1:0]  w_mux_idx;
  logic [DATA_W-1:0] w_mux_data;
  logic              w_in_range;

`ifdef BBUS_PIPE_SCAN_EN
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_cnt;
  logic             r_scan_busy;
  logic             r_scan_done;
`else
  logic w_unused_scan_start;
  assign w_unused_scan_start = i_scan_start;
`endif

  // Mux index: scan counter while scanning, source 0 on scan entry, else the select.
  always_comb begin
    w_mux_idx = i_b_sel;
`ifdef BBUS_PIPE_SCAN_EN
    if (r_state == ST_SCAN) begin
      w_mux_idx = r_cnt;
    end else if (i_scan_start) begin
      w_mux_idx = '0;
    end
`endif
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (w_mux_idx == SEL_W'(k)) begin
        w_mux_data = i_src_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_in_range = ({1'b0, i_b_sel} < NUM_SRC_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_out     <= '0;
      r_b_valid   <= 1'b0;
      r_b_idx     <= '0;
      r_sel_err   <= 1'b0;
`ifdef BBUS_PIPE_SCAN_EN
      r_state     <= ST_NORMAL;
      r_cnt       <= '0;
      r_scan_busy <= 1'b0;
      r_scan_done <= 1'b0;
`endif
    end else if (!i_stall) begin
`ifdef BBUS_PIPE_SCAN_EN
      r_scan_done <= 1'b0;
      if (r_state == ST_SCAN) begin
        r_b_out   <= w_mux_data;
        r_b_idx   <= r_cnt;
        r_b_valid <= 1'b1;
        if (r_cnt == LAST_IDX) begin
          r_scan_done <= 1'b1;
          r_scan_busy <= 1'b0;
          r_cnt       <= '0;
          r_state     <= ST_NORMAL;
        end else begin
          r_cnt <= r_cnt + SEL_W'(1);
        end
      end else if (i_scan_start) begin
        // Scan entry wins over a simultaneous select; source 0 goes out on this edge.
        r_b_out     <= w_mux_data;
        r_b_idx     <= '0;
        r_b_valid   <= 1'b1;
        r_sel_err   <= 1'b0;
        r_scan_busy <= 1'b1;
        r_cnt       <= SEL_W'(1);
        r_state     <= ST_SCAN;
      end else
`endif
      if (i_sel_valid) begin
        r_b_out   <= w_in_range ? w_mux_data : '0;
        r_b_idx   <= i_b_sel;
        r_b_valid <= 1'b1;
        r_sel_err <= ~w_in_range;
      end else begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign o_b_out     = r_b_out;
  assign o_b_valid   = r_b_valid;
  assign o_b_idx     = r_b_idx;
  assign o_sel_err   = r_sel_err;
`ifdef BBUS_PIPE_SCAN_EN
  assign o_scan_busy = r_scan_busy;
  assign o_scan_done = r_scan_done;
`else
  assign o_scan_busy = 1'b0;
  assign o_scan_done = 1'b0;
`endif

endmodule

// File: tb/tb_bbus_pipe.sv
// Directed self-checking bench for bbus_pipe at default sizing with src[k]=k+1.
// Scan scenarios run when BBUS_PIPE_SCAN_EN is defined; otherwise scan_start must be ignored.
module tb_bbus_pipe;

  localparam int unsigned DATA_W  = 19;
  localparam int unsigned NUM_SRC = 15;
  localparam int unsigned SEL_W   = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic [SEL_W-1:0]          b_sel;
  logic                      sel_valid;
  logic                      stall;
  logic                      scan_start;
  logic [DATA_W-1:0]         b_out;
  logic                      b_valid;
  logic [SEL_W-1:0]          b_idx;
  logic                      sel_err;
  logic                      scan_busy;
  logic                      scan_done;

  int checks;
  int failures;

  bbus_pipe #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_src_bus    (src_bus),
    .i_b_sel      (b_sel),
    .i_sel_valid  (sel_valid),
    .i_stall      (stall),
    .i_scan_start (scan_start),
    .o_b_out      (b_out),
    .o_b_valid    (b_valid),
    .o_b_idx      (b_idx),
    .o_sel_err    (sel_err),
    .o_scan_busy  (scan_busy),
    .o_scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel_valid = 1'b0; stall = 1'b0; scan_start = 1'b0; b_sel = '0;
    tick(); tick();
    checks++;
    if ({b_out, b_valid, b_idx, sel_err, scan_busy, scan_done} !== '0) begin
      failures++;
      $display("FAIL reset: b_out=%0d b_valid=%0b b_idx=%0d sel_err=%0b busy=%0b done=%0b, required all 0",
               b_out, b_valid, b_idx, sel_err, scan_busy, scan_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_select_all();
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      b_sel = SEL_W'(s); sel_valid = 1'b1;
      tick();
      checks++;
      if (b_out !== DATA_W'(s + 1) || b_idx !== SEL_W'(s) || b_valid !== 1'b1 || sel_err !== 1'b0) begin
        failures++;
        $display("FAIL select_%0d: b_out=%0d b_idx=%0d b_valid=%0b sel_err=%0b, required %0d %0d 1 0",
                 s, b_out, b_idx, b_valid, sel_err, s + 1, s);
      end
    end
  endtask

  task automatic test_out_of_range();
    b_sel = 4'd15; sel_valid = 1'b1;
    tick();
    checks++;
    if (b_out !== '0 || b_idx !== 4'd15 || sel_err !== 1'b1 || b_valid !== 1'b1) begin
      failures++;
      $display("FAIL oor_flag: b_out=%0d b_idx=%0d sel_err=%0b b_valid=%0b, required 0 15 1 1",
               b_out, b_idx, sel_err, b_valid);
    end
    b_sel = 4'd3;
    tick();
    checks++;
    if (b_out !== 19'd4 || sel_err !== 1'b0 || b_idx !== 4'd3) begin
      failures++;
      $display("FAIL oor_clear: b_out=%0d sel_err=%0b b_idx=%0d, required 4 0 3", b_out, sel_err, b_idx);
    end
    sel_valid = 1'b0; b_sel = 4'd8;
    tick();
    checks++;
    if (b_valid !== 1'b0 || b_out !== 19'd4 || b_idx !== 4'd3 || sel_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: b_valid=%0b b_out=%0d b_idx=%0d sel_err=%0b, required 0 4 3 0",
               b_valid, b_out, b_idx, sel_err);
    end
  endtask

  task automatic test_stall();
    b_sel = 4'd4; sel_valid = 1'b1;
    tick();
    checks++;
    if (b_out !== 19'd5) begin
      failures++;
      $display("FAIL stall_pre: b_out=%0d, required 5", b_out);
    end
    stall = 1'b1; b_sel = 4'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (b_out !== 19'd5 || b_valid !== 1'b1 || b_idx !== 4'd4) begin
        failures++;
        $display("FAIL stall_hold_%0d: b_out=%0d b_valid=%0b b_idx=%0d, required 5 1 4", c, b_out, b_valid, b_idx);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (b_out !== 19'd8 || b_idx !== 4'd7) begin
      failures++;
      $display("FAIL stall_release: b_out=%0d b_idx=%0d, required 8 7", b_out, b_idx);
    end
  endtask

`ifdef BBUS_PIPE_SCAN_EN
  task automatic test_scan();
    scan_start = 1'b1; sel_valid = 1'b1; b_sel = 4'd9;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      tick();
      if (i == 0) scan_start = 1'b0;
      if (i == int'(NUM_SRC) - 1) sel_valid = 1'b0;
      checks++;
      if (b_out !== DATA_W'(i + 1) || b_idx !== SEL_W'(i) || b_valid !== 1'b1 ||
          scan_done !== (i == int'(NUM_SRC) - 1) || scan_busy !== (i != int'(NUM_SRC) - 1)) begin
        failures++;
        $display("FAIL scan_%0d: b_out=%0d b_idx=%0d b_valid=%0b done=%0b busy=%0b, required %0d %0d 1 %0b %0b",
                 i, b_out, b_idx, b_valid, scan_done, scan_busy, i + 1, i,
                 i == int'(NUM_SRC) - 1, i != int'(NUM_SRC) - 1);
      end
    end
    tick();
    checks++;
    if (scan_done !== 1'b0 || scan_busy !== 1'b0 || b_valid !== 1'b0 || b_out !== 19'd15) begin
      failures++;
      $display("FAIL scan_end: done=%0b busy=%0b b_valid=%0b b_out=%0d, required 0 0 0 15",
               scan_done, scan_busy, b_valid, b_out);
    end
  endtask

  task automatic test_scan_stall_back_to_back();
    scan_start = 1'b1; sel_valid = 1'b0;
    tick();
    scan_start = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (b_out !== 19'd7 || b_idx !== 4'd6 || scan_busy !== 1'b1) begin
        failures++;
        $display("FAIL scan_stall_%0d: b_out=%0d b_idx=%0d busy=%0b, required 7 6 1", c, b_out, b_idx, scan_busy);
      end
    end
    stall = 1'b0;
    for (int i = 7; i < int'(NUM_SRC); i++) begin
      tick();
      checks++;
      if (b_out !== DATA_W'(i + 1) || b_idx !== SEL_W'(i) || b_valid !== 1'b1) begin
        failures++;
        $display("FAIL scan_resume_%0d: b_out=%0d b_idx=%0d b_valid=%0b, required %0d %0d 1",
                 i, b_out, b_idx, b_valid, i + 1, i);
      end
    end
    stall = 1'b1;
    tick();
    checks++;
    if (scan_done !== 1'b1 || b_out !== 19'd15) begin
      failures++;
      $display("FAIL done_stall_hold: done=%0b b_out=%0d, required 1 15", scan_done, b_out);
    end
    stall = 1'b0; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checks++;
    if (scan_done !== 1'b0 || scan_busy !== 1'b1 || b_out !== 19'd1 || b_idx !== 4'd0 || b_valid !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back: done=%0b busy=%0b b_out=%0d b_idx=%0d b_valid=%0b, required 0 1 1 0 1",
               scan_done, scan_busy, b_out, b_idx, b_valid);
    end
  endtask
`else
  task automatic test_scan_disabled();
    scan_start = 1'b1; sel_valid = 1'b1; b_sel = 4'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (b_out !== 19'd10 || b_idx !== 4'd9 || scan_busy !== 1'b0 || scan_done !== 1'b0) begin
        failures++;
        $display("FAIL scan_ignored_%0d: b_out=%0d b_idx=%0d busy=%0b done=%0b, required 10 9 0 0",
                 c, b_out, b_idx, scan_busy, scan_done);
      end
    end
    scan_start = 1'b0; sel_valid = 1'b0;
    tick();
  endtask
`endif

  // Async reset mid-activity: scanning to index 10 when the scan exists, else a select of 10.
  task automatic test_async_reset();
    int done_seen;
`ifdef BBUS_PIPE_SCAN_EN
    scan_start = 1'b1; sel_valid = 1'b0;
    tick();
    scan_start = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
`else
    b_sel = 4'd10; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
`endif
    checks++;
    if (b_idx !== 4'd10 || b_out !== 19'd11) begin
      failures++;
      $display("FAIL pre_reset: b_idx=%0d b_out=%0d, required 10 11", b_idx, b_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b_out, b_valid, b_idx, sel_err, scan_busy, scan_done} !== '0) begin
      failures++;
      $display("FAIL async_reset: b_out=%0d b_valid=%0b b_idx=%0d sel_err=%0b busy=%0b done=%0b, required all 0",
               b_out, b_valid, b_idx, sel_err, scan_busy, scan_done);
    end
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (scan_done !== 1'b0 || scan_busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_abort: scan activity after reset seen on %0d cycles, required 0", done_seen);
    end
    b_sel = 4'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    checks++;
    if (b_out !== 19'd3 || b_idx !== 4'd2 || b_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_sel: b_out=%0d b_idx=%0d b_valid=%0b, required 3 2 1", b_out, b_idx, b_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < int'(NUM_SRC); k++) src_bus[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
    test_reset();
    test_select_all();
    test_out_of_range();
    test_stall();
`ifdef BBUS_PIPE_SCAN_EN
    test_scan();
    test_scan_stall_back_to_back();
`else
    test_scan_disabled();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
